// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a single outstanding memory read
// and a two-entry FIFO of {pc, instruction} pairs in front of decode.
// Index 0 of every address/data bus is the MSB.
module instr_fetch #(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int BUF_DEPTH = 2   // only 2 is supported
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active low
  input  logic [0:ADDR_W-1]  pc_in,
  output logic               pc_en,
  input  logic               flush,
  output logic               imem_req,
  output logic [0:ADDR_W-1]  imem_addr,
  input  logic               imem_ack,
  input  logic [0:INSTR_W-1] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [0:INSTR_W-1] ir_out,
  output logic [0:ADDR_W-1]  ir_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [0:ADDR_W-1]  req_pc_q, req_pc_d;
  logic               pc_en_q, pc_en_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [0:INSTR_W-1] buf_instr_q [BUF_DEPTH];
  logic [0:ADDR_W-1]  buf_pc_q    [BUF_DEPTH];

  logic               pending;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     occupancy;

  // A read is outstanding whenever the FSM is away from IDLE.
  assign pending   = (state_q != IDLE);
  // Buffered entries plus the in-flight one; a new read may only start
  // when there is guaranteed room for its data.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pending};
  // Returning data is kept only if no flush arrives with it.
  assign push      = (state_q == WAIT) && imem_ack && !flush;
  // An empty buffer ignores ir_ready.
  assign pop       = (count_q != '0) && ir_ready;

  // FSM next state, request capture and the one-cycle pc_en pulse
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    pc_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && (occupancy < DEPTH_OCC)) begin
          state_d  = WAIT;
          req_pc_d = pc_in;
          pc_en_d  = 1'b1;
        end
      end
      WAIT: begin
        // An ack ends the read whether or not flush discards its data.
        if (imem_ack) begin
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Wait out the abandoned read; its data is never buffered.
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO occupancy and pointer update; flush wins over push and pop
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
      pc_en_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      pc_en_q  <= pc_en_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Fetch buffer storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  // The request stays asserted with a stable address through WAIT and
  // DRAIN so the memory handshake completes; DRAIN never starts a new read.
  assign imem_req  = pending;
  assign imem_addr = req_pc_q;
  assign pc_en     = pc_en_q;

  assign ir_valid  = (count_q != '0);
  assign ir_out    = buf_instr_q[rd_ptr_q];
  assign ir_pc     = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against hand-computed values.
module tb_instr_fetch;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst;
  logic [0:ADDR_W-1]  pc_in;
  logic               pc_en;
  logic               flush;
  logic               imem_req;
  logic [0:ADDR_W-1]  imem_addr;
  logic               imem_ack;
  logic [0:INSTR_W-1] imem_rdata;
  logic               ir_valid;
  logic               ir_ready;
  logic [0:INSTR_W-1] ir_out;
  logic [0:ADDR_W-1]  ir_pc;

  int n_checks;
  int n_errors;
  int mem_lat;
  int wait_cnt;
  bit mem_on;

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .BUF_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_en     (pc_en),
    .flush     (flush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: advance the PC model if pc_en was high, then the memory model
  // answers after mem_lat cycles of imem_req with 0xA0000000+addr.
  task automatic tick();
    logic adv;
    adv = pc_en;
    @(posedge clk);
    #1;
    if (adv) pc_in = pc_in + 32'd1;
    if (mem_on) begin
      if (imem_req) begin
        wait_cnt = wait_cnt + 1;
        if (wait_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = 32'hA000_0000 + imem_addr;
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic do_reset(input logic [0:ADDR_W-1] start_pc);
    rst        = 1'b0;
    flush      = 1'b0;
    ir_ready   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    pc_in      = start_pc;
    mem_on     = 1'b1;
    mem_lat    = 1;
    wait_cnt   = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n_pcen;
    n_checks = 0;
    n_errors = 0;

    // (a) reset values, then 1-cycle memory with decode always ready
    do_reset(32'd200);
    ir_ready = 1'b1;
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, 0);
    check_eq("rst_pc_en", pc_en, 0);
    check_eq("rst_ir_valid", ir_valid, 0);
    check_eq("rst_ir_out", ir_out, 0);
    check_eq("rst_ir_pc", ir_pc, 0);
    tick();
    check_eq("a_first_req", imem_req, 1);
    check_eq("a_first_addr", imem_addr, 200);
    check_eq("a_first_pc_en", pc_en, 1);
    exp_pc = 32'd200;
    n_pcen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ir_valid) begin
        check_eq("a_ir_pc", ir_pc, exp_pc);
        check_eq("a_ir_out", ir_out, 32'hA000_0000 + exp_pc);
        exp_pc = exp_pc + 32'd1;
      end
      if (pc_en) begin
        n_pcen++;
        check_eq("a_pc_en_addr", imem_addr, pc_in);
      end
    end
    check_eq("a_fetch_count", exp_pc - 32'd200, 10);
    check_eq("a_pc_en_count", n_pcen, 10);
    $display("scenario a: %0d fetches delivered in order", exp_pc - 32'd200);

    // (b) decode stalled: buffer fills to 2 and fetch stops
    do_reset(32'd200);
    for (int c = 0; c < 4; c++) tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("b_stall_req", imem_req, 0);
      check_eq("b_stall_pc_en", pc_en, 0);
      check_eq("b_full_valid", ir_valid, 1);
    end
    check_eq("b_head_pc", ir_pc, 200);
    check_eq("b_head_out", ir_out, 32'hA000_00C8);
    ir_ready = 1'b1;
    tick();
    check_eq("b_second_pc", ir_pc, 201);
    check_eq("b_second_out", ir_out, 32'hA000_00C9);
    check_eq("b_second_valid", ir_valid, 1);
    check_eq("b_still_stalled", imem_req, 0);
    tick();
    check_eq("b_empty_valid", ir_valid, 0);
    check_eq("b_resume_req", imem_req, 1);
    check_eq("b_resume_addr", imem_addr, 202);
    $display("scenario b: stall with two entries, drained 200 then 201");

    // (c) 5-cycle memory latency: request held, no second request
    do_reset(32'd300);
    ir_ready = 1'b1;
    mem_lat  = 5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_eq("c_req_held", imem_req, 1);
      check_eq("c_addr_held", imem_addr, 300);
      check_eq("c_pc_en", pc_en, (c == 1));
    end
    tick();
    check_eq("c_req_drop", imem_req, 0);
    check_eq("c_valid", ir_valid, 1);
    check_eq("c_ir_pc", ir_pc, 300);
    check_eq("c_ir_out", ir_out, 32'hA000_012C);
    tick();
    check_eq("c_next_req", imem_req, 1);
    check_eq("c_next_addr", imem_addr, 301);
    $display("scenario c: 5-cycle read held stable");

    // (d) flush during WAIT; late ack is discarded, refetch from 400
    do_reset(32'd200);
    ir_ready = 1'b1;
    mem_lat  = 4;
    tick();
    check_eq("d_req", imem_req, 1);
    check_eq("d_addr", imem_addr, 200);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pc_in = 32'd400;
    check_eq("d_flush_pc_en", pc_en, 0);
    check_eq("d_flush_valid", ir_valid, 0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      check_eq("d_drain_pc_en", pc_en, 0);
      check_eq("d_drain_valid", ir_valid, 0);
    end
    check_eq("d_drained_req", imem_req, 0);
    tick();
    check_eq("d_new_req", imem_req, 1);
    check_eq("d_new_addr", imem_addr, 400);
    check_eq("d_new_pc_en", pc_en, 1);
    for (int c = 7; c <= 9; c++) begin
      tick();
      check_eq("d_wait_valid", ir_valid, 0);
    end
    tick();
    check_eq("d_valid", ir_valid, 1);
    check_eq("d_ir_pc", ir_pc, 400);
    check_eq("d_ir_out", ir_out, 32'hA000_0190);
    $display("scenario d: flushed read discarded, refetch at 400");

    // (e) flush with full buffer, pop and ack in the same cycle
    do_reset(32'd200);
    for (int c = 0; c < 5; c++) tick();
    check_eq("e_full_valid", ir_valid, 1);
    check_eq("e_full_pc", ir_pc, 200);
    mem_on     = 1'b0;
    flush      = 1'b1;
    ir_ready   = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    flush    = 1'b0;
    imem_ack = 1'b0;
    mem_on   = 1'b1;
    check_eq("e_flush_valid", ir_valid, 0);
    check_eq("e_flush_req", imem_req, 0);
    check_eq("e_flush_pc_en", pc_en, 0);
    tick();
    check_eq("e_after_valid", ir_valid, 0);
    check_eq("e_after_req", imem_req, 1);
    check_eq("e_after_addr", imem_addr, 202);
    tick();
    check_eq("e_new_valid", ir_valid, 1);
    check_eq("e_new_pc", ir_pc, 202);
    check_eq("e_new_out", ir_out, 32'hA000_00CA);
    $display("scenario e: flush cleared a full buffer");

    // (f) asynchronous reset mid-WAIT, then a stray ack after release
    do_reset(32'd500);
    tick();
    tick();
    mem_lat = 5;
    tick();
    check_eq("f_pre_valid", ir_valid, 1);
    check_eq("f_pre_req", imem_req, 1);
    #3;
    rst = 1'b0;
    #1;
    check_eq("f_rst_req", imem_req, 0);
    check_eq("f_rst_addr", imem_addr, 0);
    check_eq("f_rst_pc_en", pc_en, 0);
    check_eq("f_rst_valid", ir_valid, 0);
    check_eq("f_rst_out", ir_out, 0);
    check_eq("f_rst_pc", ir_pc, 0);
    mem_on   = 1'b0;
    imem_ack = 1'b0;
    pc_in    = 32'd500;
    tick();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check_eq("f_stray_valid", ir_valid, 0);
    check_eq("f_first_req", imem_req, 1);
    check_eq("f_first_addr", imem_addr, 500);
    check_eq("f_first_pc_en", pc_en, 1);
    mem_on   = 1'b1;
    mem_lat  = 1;
    wait_cnt = 0;
    tick();
    tick();
    check_eq("f_valid", ir_valid, 1);
    check_eq("f_ir_pc", ir_pc, 500);
    check_eq("f_ir_out", ir_out, 32'hA000_01F4);
    $display("scenario f: async reset abandoned read, stray ack ignored");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
